// File: rtl/mips_cpu.sv
// Single-cycle 32-bit MIPS integer core: one instruction fetched,
// executed and committed per clock through separate inst/data ports.
module mips_cpu #(
    parameter logic [31:0] RESET_PC = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic [31:0] data_out,
    output logic [31:0] inst_addr,
    output logic [31:0] data_addr,
    output logic [31:0] data_in,
    output logic        mem_read,
    output logic        mem_write
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;

    assign op     = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm    = instr[15:0];
    assign target = instr[25:0];

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] rf_q [32];

    logic [31:0] pc_plus4;
    logic [31:0] sext_imm;
    logic [31:0] zext_imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] br_target;
    logic [31:0] j_target;

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        mem_rd;
    logic        mem_wr;

    assign pc_plus4  = pc_q + 32'd4;
    assign sext_imm  = {{16{imm[15]}}, imm};
    assign zext_imm  = {16'd0, imm};
    assign br_target = pc_plus4 + {sext_imm[29:0], 2'b00};
    assign j_target  = {pc_plus4[31:28], target, 2'b00};

    // $0 is hardwired to zero on read; its storage is never written.
    assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

    always_comb begin
        pc_d   = pc_plus4;
        rf_we  = 1'b0;
        rf_wa  = rt;
        rf_wd  = 32'd0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        case (op)
            6'h00: begin
                rf_wa = rd;
                rf_we = 1'b1;
                case (funct)
                    6'h20, 6'h21: rf_wd = rs_val + rt_val;
                    6'h22, 6'h23: rf_wd = rs_val - rt_val;
                    6'h24: rf_wd = rs_val & rt_val;
                    6'h25: rf_wd = rs_val | rt_val;
                    6'h26: rf_wd = rs_val ^ rt_val;
                    6'h27: rf_wd = ~(rs_val | rt_val);
                    6'h2A: rf_wd = {31'd0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: rf_wd = {31'd0, rs_val < rt_val};
                    6'h00: rf_wd = rt_val << shamt;
                    6'h02: rf_wd = rt_val >> shamt;
                    6'h03: rf_wd = $signed(rt_val) >>> shamt;
                    6'h08: begin
                        rf_we = 1'b0;
                        pc_d  = rs_val;
                    end
                    default: rf_we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin
                rf_we = 1'b1;
                rf_wd = rs_val + sext_imm;
            end
            6'h0C: begin
                rf_we = 1'b1;
                rf_wd = rs_val & zext_imm;
            end
            6'h0D: begin
                rf_we = 1'b1;
                rf_wd = rs_val | zext_imm;
            end
            6'h0E: begin
                rf_we = 1'b1;
                rf_wd = rs_val ^ zext_imm;
            end
            6'h0A: begin
                rf_we = 1'b1;
                rf_wd = {31'd0, $signed(rs_val) < $signed(sext_imm)};
            end
            6'h0B: begin
                rf_we = 1'b1;
                rf_wd = {31'd0, rs_val < sext_imm};
            end
            6'h0F: begin
                rf_we = 1'b1;
                rf_wd = {imm, 16'd0};
            end
            6'h23: begin
                rf_we  = 1'b1;
                rf_wd  = data_out;
                mem_rd = 1'b1;
            end
            6'h2B: mem_wr = 1'b1;
            6'h04: if (rs_val == rt_val) pc_d = br_target;
            6'h05: if (rs_val != rt_val) pc_d = br_target;
            6'h02: pc_d = j_target;
            6'h03: begin
                pc_d  = j_target;
                rf_we = 1'b1;
                rf_wa = 5'd31;
                rf_wd = pc_plus4;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else begin
            pc_q <= pc_d;
            if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
        end
    end

    assign inst_addr = pc_q;
    assign data_addr = rs_val + sext_imm;
    assign data_in   = rt_val;
    // Strobes are masked in reset so the memory never sees a discarded store.
    assign mem_read  = mem_rd & ~rst;
    assign mem_write = mem_wr & ~rst;

endmodule

// File: tb/tb_mips_cpu.sv
// Bench for mips_cpu: directed and random programs, checked per cycle
// against an instruction-level reference interpreter via a scoreboard.
module tb_mips_cpu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr;
    logic [31:0] data_out;
    logic [31:0] inst_addr;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;

    mips_cpu #(.RESET_PC(32'h0000_1000)) dut (
        .clk(clk),
        .rst(rst),
        .instr(instr),
        .data_out(data_out),
        .inst_addr(inst_addr),
        .data_addr(data_addr),
        .data_in(data_in),
        .mem_read(mem_read),
        .mem_write(mem_write)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:4095];
    logic        ld_en = 1'b0;
    logic [11:0] ld_idx = 12'd0;
    logic [31:0] ld_data = 32'd0;

    assign instr    = mem[inst_addr[13:2]];
    assign data_out = mem[data_addr[13:2]];

    always @(posedge clk) begin
        if (ld_en) mem[ld_idx] <= ld_data;
        else if (mem_write) mem[data_addr[13:2]] <= data_in;
    end

    int n_checks = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] din;
        logic        mr;
        logic        mw;
    } exp_t;

    exp_t exp_q[$];

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pc", inst_addr, e.pc);
            chk("mem_read", 32'(mem_read), 32'(e.mr));
            chk("mem_write", 32'(mem_write), 32'(e.mw));
            if (e.mr || e.mw) chk("data_addr", data_addr, e.addr);
            if (e.mw) chk("data_in", data_in, e.din);
        end
    end

    // Reference interpreter state
    logic [31:0] m_mem [0:4095];
    logic [31:0] m_reg [32];
    logic [31:0] m_pc;
    logic [31:0] halt_pc;
    logic [31:0] prog[$];

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_pc = 32'h0000_1000;
    endtask

    task automatic model_step(input bit commit, output exp_t e);
        logic [31:0] ir, a, b, simm, zimm, npc, wd, ea;
        logic [5:0]  op, fn;
        logic [4:0]  sh, wr;
        bit          we;
        ir   = m_mem[m_pc[13:2]];
        op   = ir[31:26];
        fn   = ir[5:0];
        sh   = ir[10:6];
        a    = m_reg[ir[25:21]];
        b    = m_reg[ir[20:16]];
        simm = {{16{ir[15]}}, ir[15:0]};
        zimm = {16'd0, ir[15:0]};
        npc  = m_pc + 32'd4;
        ea   = a + simm;
        we   = 1'b0;
        wr   = ir[20:16];
        wd   = 32'd0;
        e.pc = m_pc;
        e.addr = ea;
        e.din = b;
        e.mr = 1'b0;
        e.mw = 1'b0;
        case (op)
            6'h00: begin
                wr = ir[15:11];
                we = 1'b1;
                case (fn)
                    6'h20, 6'h21: wd = a + b;
                    6'h22, 6'h23: wd = a - b;
                    6'h24: wd = a & b;
                    6'h25: wd = a | b;
                    6'h26: wd = a ^ b;
                    6'h27: wd = ~(a | b);
                    6'h2A: wd = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: wd = (a < b) ? 32'd1 : 32'd0;
                    6'h00: wd = b << sh;
                    6'h02: wd = b >> sh;
                    6'h03: wd = $signed(b) >>> sh;
                    6'h08: begin
                        we = 1'b0;
                        npc = a;
                    end
                    default: we = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin we = 1'b1; wd = a + simm; end
            6'h0C: begin we = 1'b1; wd = a & zimm; end
            6'h0D: begin we = 1'b1; wd = a | zimm; end
            6'h0E: begin we = 1'b1; wd = a ^ zimm; end
            6'h0A: begin we = 1'b1; wd = ($signed(a) < $signed(simm)) ? 32'd1 : 32'd0; end
            6'h0B: begin we = 1'b1; wd = (a < simm) ? 32'd1 : 32'd0; end
            6'h0F: begin we = 1'b1; wd = {ir[15:0], 16'd0}; end
            6'h23: begin we = 1'b1; wd = m_mem[ea[13:2]]; e.mr = 1'b1; end
            6'h2B: begin
                e.mw = 1'b1;
                if (commit) m_mem[ea[13:2]] = b;
            end
            6'h04: if (a == b) npc = m_pc + 32'd4 + (simm << 2);
            6'h05: if (a != b) npc = m_pc + 32'd4 + (simm << 2);
            6'h02: npc = {npc[31:28], ir[25:0], 2'b00};
            6'h03: begin
                npc = {npc[31:28], ir[25:0], 2'b00};
                we = 1'b1;
                wr = 5'd31;
                wd = m_pc + 32'd4;
            end
            default: ;
        endcase
        if (commit) begin
            if (we && wr != 5'd0) m_reg[wr] = wd;
            m_pc = npc;
        end
    endtask

    function automatic logic [31:0] r_enc(int fn, int rs, int rt, int rd, int sh);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
    endfunction

    function automatic logic [31:0] i_enc(int op, int rs, int rt, int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_enc(int op, int slot);
        logic [31:0] ta;
        ta = 32'h0000_1000 + 32'(4 * slot);
        return {6'(op), ta[27:2]};
    endfunction

    function automatic void add_dump_and_halt();
        for (int r = 0; r < 32; r++) prog.push_back(i_enc(6'h2B, 0, r, 32'h3000 + 4 * r));
        halt_pc = 32'h0000_1000 + 32'(4 * prog.size());
        prog.push_back(j_enc(2, prog.size()));
    endfunction

    function automatic void build_directed();
        prog.delete();
        prog.push_back(i_enc(8, 0, 1, 5));
        prog.push_back(i_enc(8, 0, 2, 16'hFFFD));
        prog.push_back(r_enc(6'h20, 1, 2, 3, 0));
        prog.push_back(r_enc(6'h2A, 2, 1, 4, 0));
        prog.push_back(i_enc(4, 1, 1, 2));
        prog.push_back(i_enc(8, 0, 9, 1));
        prog.push_back(i_enc(8, 0, 9, 1));
        prog.push_back(i_enc(5, 1, 1, 2));
        prog.push_back({6'h03, 26'h000_0410});
        prog.push_back(r_enc(6'h2B, 2, 1, 5, 0));
        prog.push_back(i_enc(6'h0F, 0, 6, 0));
        prog.push_back(i_enc(6'h0D, 6, 6, 16'h2000));
        prog.push_back(i_enc(8, 0, 7, 16'h0055));
        prog.push_back(i_enc(6'h2B, 6, 7, 4));
        prog.push_back(i_enc(6'h23, 6, 8, 4));
        prog.push_back(j_enc(2, 17));
        prog.push_back(r_enc(6'h08, 31, 0, 0, 0));
        prog.push_back(i_enc(8, 0, 0, 7));
        prog.push_back(32'hFC22_1234);
        add_dump_and_halt();
    endfunction

    function automatic logic [31:0] rand_instr(int i);
        int fl[13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                       6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03};
        int il[8] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0B, 6'h0F};
        int sel = int'($urandom_range(0, 99));
        int rs = int'($urandom_range(0, 16));
        int rt = int'($urandom_range(0, 16));
        int rd = int'($urandom_range(1, 15));
        int off = 4 * int'($urandom_range(0, 63));
        if (sel < 35)
            return r_enc(fl[$urandom_range(0, 12)], rs, rt, (sel == 0) ? 0 : rd,
                         int'($urandom_range(0, 31)));
        if (sel < 65)
            return i_enc(il[$urandom_range(0, 7)], rs, rd, int'($urandom_range(0, 65535)));
        if (sel < 75) return i_enc(6'h2B, 16, rt, off);
        if (sel < 85) return i_enc(6'h23, 16, rd, off);
        if (sel < 92)
            return i_enc((sel < 89) ? 4 : 5, rs, (sel % 2 == 0) ? rs : rt,
                         int'($urandom_range(1, 3)));
        if (sel < 95) return j_enc(2, i + 1 + int'($urandom_range(0, 2)));
        if (sel < 97) return j_enc(3, i + 1 + int'($urandom_range(0, 2)));
        if (sel == 97) return {6'h3F, 26'($urandom)};
        if (sel == 98) return {6'h10, 26'($urandom)};
        return r_enc(6'h01, rs, rt, rd, 0);
    endfunction

    function automatic void build_random(int n);
        prog.delete();
        prog.push_back(i_enc(6'h0F, 0, 16, 0));
        prog.push_back(i_enc(6'h0D, 16, 16, 16'h2000));
        for (int i = 0; i < n; i++) prog.push_back(rand_instr(prog.size()));
        add_dump_and_halt();
    endfunction

    task automatic load_word(input logic [11:0] idx, input logic [31:0] w);
        ld_en = 1'b1;
        ld_idx = idx;
        ld_data = w;
        m_mem[idx] = w;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) load_word(12'h400 + 12'(i), prog[i]);
        for (int i = 0; i < 64; i++) load_word(12'h800 + 12'(i), 32'd0);
        for (int i = 0; i < 32; i++) load_word(12'hC00 + 12'(i), 32'd0);
    endtask

    task automatic reset_checks();
        @(negedge clk);
        chk("rst_pc", inst_addr, 32'h0000_1000);
        chk("rst_mem_read", 32'(mem_read), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        #1;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 5000; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_full();
        exp_t e;
        int steps = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        do begin
            model_step(1'b1, e);
            exp_q.push_back(e);
            steps++;
        end while (e.pc != halt_pc && steps < 3000);
        wait_drain();
        rst = 1'b1;
    endtask

    // Run until a store is about to commit, then reset over it.
    task automatic run_partial_and_reset();
        exp_t e;
        int steps = 0;
        logic [11:0] sidx;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        while (steps < 3000 && !(steps >= 5 && m_mem[m_pc[13:2]][31:26] == 6'h2B)) begin
            model_step(1'b1, e);
            exp_q.push_back(e);
            steps++;
        end
        model_step(1'b0, e);
        exp_q.push_back(e);
        sidx = e.addr[13:2];
        wait_drain();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_pc", inst_addr, 32'h0000_1000);
        chk("midrst_mem_write", 32'(mem_write), 32'd0);
        chk("midrst_mem_read", 32'(mem_read), 32'd0);
        chk("midrst_store_dropped", mem[sidx], m_mem[sidx]);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        build_directed();
        load_prog();
        reset_checks();
        run_full();
        chk("dir_r0", mem[12'hC00], 32'd0);
        chk("dir_r1", mem[12'hC01], 32'd5);
        chk("dir_r2", mem[12'hC02], 32'hFFFF_FFFD);
        chk("dir_r3_add", mem[12'hC03], 32'd2);
        chk("dir_r4_slt", mem[12'hC04], 32'd1);
        chk("dir_r5_sltu", mem[12'hC05], 32'd0);
        chk("dir_r6_base", mem[12'hC06], 32'h0000_2000);
        chk("dir_r8_lw", mem[12'hC08], 32'h0000_0055);
        chk("dir_r9_skipped", mem[12'hC09], 32'd0);
        chk("dir_r31_jal", mem[12'hC1F], 32'h0000_1024);
        chk("dir_sw_word", mem[12'h801], 32'h0000_0055);

        for (int p = 0; p < 3; p++) begin
            build_random(150);
            load_prog();
            reset_checks();
            run_partial_and_reset();
            run_full();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
